decode_pipe_ctrl: RTL
=====================

DECODE_PIPE_CTRL -- requirements
Module: decode_pipe_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width of in_src1, in_src2, in_dst and out_dst.
REQ-002 Parameter HAZARD_EN, default 1, load-use hazard detection enabled when 1; when 0 hazard is never raised.
REQ-003 Parameter CNT_W, default 8, width of the illegal-opcode counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 in_valid  in  1  upstream instruction present.
REQ-007 in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
REQ-008 in_opcode  in  6  instruction opcode.
REQ-009 in_src1, in_src2  in  REG_AW each  source register addresses.
REQ-010 in_dst  in  REG_AW  destination register address.
REQ-011 flush  in  1  taken branch; squash in-flight decode.
REQ-012 out_ready  in  1  execute stage can accept.
REQ-013 out_valid  out  1  output register holds a real instruction.
REQ-014 out_exe_cmd  out  4  ALU command.
REQ-015 out_branch_type  out  2  opcode[1:0] for branches, else 0.
REQ-016 out_is_branch, out_is_imm, out_st_or_bne  out  1 each  decoded flags.
REQ-017 out_mem_read, out_mem_write, out_wb_en  out  1 each  memory/writeback enables.
REQ-018 out_dst  out  REG_AW  registered in_dst.
REQ-019 out_illegal  out  1  registered instruction had an undefined opcode.
REQ-020 ill_cnt  out  CNT_W  saturating count of accepted illegal opcodes.

Function
REQ-021 Decode (opcode:cmd) SHALL be 0:0 NOP, 1:0, 3:2, 5:4, 6:5, 7:6, 8:7, 9:8, 10:8, 11:9, 12:10, 32:0, 33:2, 36:0 LD, 37:0 ST, 40/41/42:0 branches; every other opcode is illegal.
REQ-022 is_imm SHALL be 1 for 32,33,36,37,40,41,42; st_or_bne for 37,41; mem_read for 36; mem_write for 37; is_branch for 40,41,42; wb_en 1 for all legal opcodes except 0,37,40,41,42.
REQ-023 Illegal opcode SHALL decode as NOP (all control 0) with out_illegal=1; ill_cnt increments on acceptance and saturates at all-ones.
REQ-024 Output register SHALL load when load_en = out_ready || !out_valid; otherwise all outputs hold.
REQ-025 Hazard SHALL be HAZARD_EN && out_valid && out_mem_read && in_valid && (out_dst==in_src1 || (out_dst==in_src2 && (!out_is_imm... of incoming) i.e. incoming is not immediate or is ST/BNE)).
REQ-026 in_ready SHALL equal load_en && (!hazard || flush), combinational.
REQ-027 On load with hazard and no flush: bubble loaded (out_valid=0, all controls 0), input held; next cycle hazard clears as output no longer holds the load.
REQ-028 On load without hazard or flush: out_valid<=in_valid; decoded fields from the accepted instruction; latency exactly 1 cycle.
REQ-029 flush SHALL force out_valid<=0 and controls 0 next cycle regardless of out_ready, and SHALL discard any concurrent input (accepted, not counted as illegal); flush beats hazard.
REQ-030 Bubble/invalid output SHALL always present out_wb_en=0, out_mem_write=0, out_mem_read=0.

Reset
REQ-031 rst_n low at a clock edge SHALL clear out_valid, all decoded outputs, out_dst, out_illegal and ill_cnt to 0, discarding any in-flight instruction; in_ready is 0 while rst_n low.

Structure
REQ-032 Opcode constants, ALU command constants and the decoded-control record typedef SHALL live in shared package mips_ctrl_pkg; the combinational decode table SHALL be sub-module ctrl_decode (opcode in, control record + illegal out).

Verification
REQ-033 Reset, then opcodes 1,3,32,36,37,41 back-to-back, out_ready=1 -> each appears 1 cycle later with cmd 0,2,0,0,0,0 and flags per REQ-022.
REQ-034 LD dst=4 then ADD src1=4 -> in_ready=0 one cycle, one bubble, ADD emitted next cycle; repeat with HAZARD_EN=0 -> no bubble.
REQ-035 LD dst=4 then ADDI src2=4 -> no stall; LD dst=4 then ST src2=4 -> one-cycle stall.
REQ-036 out_ready=0 for 3 cycles holding ADD -> outputs stable, in_ready=0; flush asserted in that window -> out_valid=0 next cycle.
REQ-037 300 illegal opcodes (e.g. 63) with CNT_W=8 -> out_illegal=1 each, wb_en=0, ill_cnt saturates at 255; rst_n low mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/ALU-command constants and the decoded-control record for the decode stage.
package mips_ctrl_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned CMD_W = 4;
    localparam int unsigned BT_W  = 2;

    // Instruction opcodes
    localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd3;
    localparam logic [OP_W-1:0] OP_AND  = 6'd5;
    localparam logic [OP_W-1:0] OP_OR   = 6'd6;
    localparam logic [OP_W-1:0] OP_NOR  = 6'd7;
    localparam logic [OP_W-1:0] OP_XOR  = 6'd8;
    localparam logic [OP_W-1:0] OP_SLA  = 6'd9;
    localparam logic [OP_W-1:0] OP_SLL  = 6'd10;
    localparam logic [OP_W-1:0] OP_SRA  = 6'd11;
    localparam logic [OP_W-1:0] OP_SRL  = 6'd12;
    localparam logic [OP_W-1:0] OP_ADDI = 6'd32;
    localparam logic [OP_W-1:0] OP_SUBI = 6'd33;
    localparam logic [OP_W-1:0] OP_LD   = 6'd36;
    localparam logic [OP_W-1:0] OP_ST   = 6'd37;
    localparam logic [OP_W-1:0] OP_BEZ  = 6'd40;
    localparam logic [OP_W-1:0] OP_BNE  = 6'd41;
    localparam logic [OP_W-1:0] OP_JMP  = 6'd42;

    // ALU commands presented to execute
    typedef enum logic [CMD_W-1:0] {
        CMD_ADD = 4'd0,
        CMD_SUB = 4'd2,
        CMD_AND = 4'd4,
        CMD_OR  = 4'd5,
        CMD_NOR = 4'd6,
        CMD_XOR = 4'd7,
        CMD_SHL = 4'd8,
        CMD_SAR = 4'd9,
        CMD_SHR = 4'd10
    } alu_cmd_t;

    // Decoded control record carried from decode to execute
    typedef struct packed {
        alu_cmd_t          exe_cmd;
        logic [BT_W-1:0]   branch_type;
        logic              is_branch;
        logic              is_imm;
        logic              st_or_bne;
        logic              mem_read;
        logic              mem_write;
        logic              wb_en;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(0);

    // An instruction reads src2 as a register unless it is an immediate form,
    // except ST/BNE which use the immediate and still read src2.
    function automatic logic uses_src2(input ctrl_t c);
        return !c.is_imm || c.st_or_bne;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode table: opcode in, control record and illegal flag out.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output ctrl_t           ctrl,
    output logic            illegal
);

    // Table lookup; undefined opcodes fall back to an all-zero NOP with illegal set
    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_NOP: begin
            end
            OP_ADD: begin
                ctrl.exe_cmd = CMD_ADD;
                ctrl.wb_en   = 1'b1;
            end
            OP_SUB: begin
                ctrl.exe_cmd = CMD_SUB;
                ctrl.wb_en   = 1'b1;
            end
            OP_AND: begin
                ctrl.exe_cmd = CMD_AND;
                ctrl.wb_en   = 1'b1;
            end
            OP_OR: begin
                ctrl.exe_cmd = CMD_OR;
                ctrl.wb_en   = 1'b1;
            end
            OP_NOR: begin
                ctrl.exe_cmd = CMD_NOR;
                ctrl.wb_en   = 1'b1;
            end
            OP_XOR: begin
                ctrl.exe_cmd = CMD_XOR;
                ctrl.wb_en   = 1'b1;
            end
            OP_SLA, OP_SLL: begin
                ctrl.exe_cmd = CMD_SHL;
                ctrl.wb_en   = 1'b1;
            end
            OP_SRA: begin
                ctrl.exe_cmd = CMD_SAR;
                ctrl.wb_en   = 1'b1;
            end
            OP_SRL: begin
                ctrl.exe_cmd = CMD_SHR;
                ctrl.wb_en   = 1'b1;
            end
            OP_ADDI: begin
                ctrl.exe_cmd = CMD_ADD;
                ctrl.is_imm  = 1'b1;
                ctrl.wb_en   = 1'b1;
            end
            OP_SUBI: begin
                ctrl.exe_cmd = CMD_SUB;
                ctrl.is_imm  = 1'b1;
                ctrl.wb_en   = 1'b1;
            end
            OP_LD: begin
                ctrl.exe_cmd  = CMD_ADD;
                ctrl.is_imm   = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.wb_en    = 1'b1;
            end
            OP_ST: begin
                ctrl.exe_cmd   = CMD_ADD;
                ctrl.is_imm    = 1'b1;
                ctrl.st_or_bne = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEZ, OP_JMP: begin
                ctrl.is_imm      = 1'b1;
                ctrl.is_branch   = 1'b1;
                ctrl.branch_type = opcode[BT_W-1:0];
            end
            OP_BNE: begin
                ctrl.is_imm      = 1'b1;
                ctrl.is_branch   = 1'b1;
                ctrl.st_or_bne   = 1'b1;
                ctrl.branch_type = opcode[BT_W-1:0];
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_pipe_ctrl.sv
// Decode pipeline stage: decodes one instruction per cycle into a registered
// control record, stalls on load-use hazards, squashes on flush and counts
// illegal opcodes.
module decode_pipe_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW    = 5,
    parameter bit          HAZARD_EN = 1'b1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [REG_AW-1:0] in_src1,
    input  logic [REG_AW-1:0] in_src2,
    input  logic [REG_AW-1:0] in_dst,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CMD_W-1:0]  out_exe_cmd,
    output logic [BT_W-1:0]   out_branch_type,
    output logic              out_is_branch,
    output logic              out_is_imm,
    output logic              out_st_or_bne,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_wb_en,
    output logic [REG_AW-1:0] out_dst,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  ill_cnt
);

    ctrl_t             in_ctrl;
    logic              in_illegal;

    logic              out_valid_q;
    ctrl_t             out_ctrl_q;
    logic [REG_AW-1:0] out_dst_q;
    logic              out_illegal_q;
    logic [CNT_W-1:0]  ill_cnt_q;

    logic              nxt_valid;
    ctrl_t             nxt_ctrl;
    logic [REG_AW-1:0] nxt_dst;
    logic              nxt_illegal;
    logic [CNT_W-1:0]  nxt_cnt;

    logic              load_en_c;
    logic              hazard_c;

    ctrl_decode u_decode (
        .opcode  (in_opcode),
        .ctrl    (in_ctrl),
        .illegal (in_illegal)
    );

    // Output register may advance when execute takes it or when it holds nothing
    assign load_en_c = out_ready || !out_valid_q;

    // Load-use hazard: a load sits in the output register and the incoming
    // instruction reads its destination
    assign hazard_c = HAZARD_EN
                   && out_valid_q
                   && out_ctrl_q.mem_read
                   && in_valid
                   && ((out_dst_q == in_src1)
                       || ((out_dst_q == in_src2) && uses_src2(in_ctrl)));

    // Flush lets the input through so it can be dropped in the same cycle
    assign in_ready = rst_n && load_en_c && (!hazard_c || flush);

    // Next contents of the output register and illegal counter
    always_comb begin
        nxt_valid   = out_valid_q;
        nxt_ctrl    = out_ctrl_q;
        nxt_dst     = out_dst_q;
        nxt_illegal = out_illegal_q;
        nxt_cnt     = ill_cnt_q;
        if (flush) begin
            nxt_valid   = 1'b0;
            nxt_ctrl    = CTRL_NOP;
            nxt_dst     = '0;
            nxt_illegal = 1'b0;
        end else if (load_en_c) begin
            if (hazard_c || !in_valid) begin
                nxt_valid   = 1'b0;
                nxt_ctrl    = CTRL_NOP;
                nxt_dst     = '0;
                nxt_illegal = 1'b0;
            end else begin
                nxt_valid   = 1'b1;
                nxt_ctrl    = in_ctrl;
                nxt_dst     = in_dst;
                nxt_illegal = in_illegal;
                if (in_illegal && !(&ill_cnt_q)) begin
                    nxt_cnt = ill_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Output register and counter, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_ctrl_q    <= CTRL_NOP;
            out_dst_q     <= '0;
            out_illegal_q <= 1'b0;
            ill_cnt_q     <= '0;
        end else begin
            out_valid_q   <= nxt_valid;
            out_ctrl_q    <= nxt_ctrl;
            out_dst_q     <= nxt_dst;
            out_illegal_q <= nxt_illegal;
            ill_cnt_q     <= nxt_cnt;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_exe_cmd     = out_ctrl_q.exe_cmd;
    assign out_branch_type = out_ctrl_q.branch_type;
    assign out_is_branch   = out_ctrl_q.is_branch;
    assign out_is_imm      = out_ctrl_q.is_imm;
    assign out_st_or_bne   = out_ctrl_q.st_or_bne;
    assign out_mem_read    = out_ctrl_q.mem_read;
    assign out_mem_write   = out_ctrl_q.mem_write;
    assign out_wb_en       = out_ctrl_q.wb_en;
    assign out_dst         = out_dst_q;
    assign out_illegal     = out_illegal_q;
    assign ill_cnt         = ill_cnt_q;

endmodule
